// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall bit
// positions, the four stall patterns, FSM encodings and the exception vector.
package pipe_ctrl_pkg;

    localparam int PC_W  = 32;
    localparam int CNT_W = 6;

    localparam logic [PC_W-1:0] EXC_VEC = 32'h0000_0020;

    // Bit positions inside the stall vector; 1 = hold that register.
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam int STALL_W = 6;

    // A request from stage S holds S and every register upstream of it.
    localparam logic [STALL_W-1:0] STALL_PAT_IF  = (6'b000001 << STALL_PC)
                                                 | (6'b000001 << STALL_IF);
    localparam logic [STALL_W-1:0] STALL_PAT_ID  = STALL_PAT_IF
                                                 | (6'b000001 << STALL_ID);
    localparam logic [STALL_W-1:0] STALL_PAT_EX  = STALL_PAT_ID
                                                 | (6'b000001 << STALL_EX);
    localparam logic [STALL_W-1:0] STALL_PAT_MEM = STALL_PAT_EX
                                                 | (6'b000001 << STALL_MEM);

    // WB is the last register and is never held.
    localparam logic [STALL_W-1:0] STALL_MASK = ~(6'b000001 << STALL_WB);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    // Highest requesting stage wins.
    function automatic logic [STALL_W-1:0] stall_pattern(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [STALL_W-1:0] pat;
        if (req_mem)      pat = STALL_PAT_MEM;
        else if (req_ex)  pat = STALL_PAT_EX;
        else if (req_id)  pat = STALL_PAT_ID;
        else if (req_if)  pat = STALL_PAT_IF;
        else              pat = '0;
        return pat & STALL_MASK;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the pipeline controller.
// Handshake: there is no valid/ready pair here. Stall requests are level
// signals sampled every cycle; exc_valid is a single-cycle qualifier for
// exc_is_eret/epc with no backpressure -- the controller either accepts it
// at the rising edge (state RUN) or silently drops it (FLUSH/RECOVER).
interface pipe_ctrl_if #(parameter int PC_W = pipe_ctrl_pkg::PC_W);

    logic            stallreq_if;
    logic            stallreq_id;
    logic            stallreq_ex;
    logic            stallreq_mem;
    logic            exc_valid;
    logic            exc_is_eret;
    logic [PC_W-1:0] epc;

    logic [5:0]      stall;
    logic            flush;
    logic [PC_W-1:0] new_pc;
    logic            timeout_err;

    // Stage side: raises requests and exceptions, consumes control.
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
               exc_valid, exc_is_eret, epc,
        input  stall, flush, new_pc, timeout_err
    );

    // Controller side.
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
               exc_valid, exc_is_eret, epc,
        output stall, flush, new_pc, timeout_err
    );

endinterface

// File: rtl/pipe_ctrl_stall_timer.sv
// Saturating stall-duration counter with a sticky timeout flag. The count
// runs while a stall is active and restarts on any stall-free cycle.
module pipe_ctrl_stall_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_active,
    input  logic         clear,
    output logic [W-1:0] cnt,
    output logic         timeout_err
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         timeout_q, timeout_d;

    // Count up while stalled, hold at saturation, restart otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !stall_active) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Flag rises on the same edge the count lands on saturation, then sticks.
    always_comb begin
        timeout_d = timeout_q | (cnt_d == CNT_MAX);
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign cnt         = cnt_q;
    assign timeout_err = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into the per-register
// stall vector and sequences exception/ERET flushes through RUN -> FLUSH ->
// RECOVER, redirecting fetch to the captured target during FLUSH.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       bus,
    output state_e           dbg_state,
    output logic [CNT_W-1:0] dbg_stall_cnt
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] new_pc_q, new_pc_d;

    logic               flush;
    logic [STALL_W-1:0] stall;
    logic               timeout_err;

    // State and redirect-target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
        end
    end

    // Next state: only RUN listens to exc_valid; the other two states are
    // fixed single-cycle steps because anything reported there comes from
    // instructions that are being squashed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (bus.exc_valid) state_d = ST_FLUSH;
            ST_FLUSH:   state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // Capture the redirect target together with the RUN -> FLUSH transition.
    always_comb begin
        new_pc_d = new_pc_q;
        if (state_q == ST_RUN && bus.exc_valid) begin
            new_pc_d = bus.exc_is_eret ? bus.epc : EXC_VEC;
        end
    end

    // Outputs: flush marks the FLUSH cycle; stall is zero during FLUSH and
    // while reset is held, otherwise follows requests in the same cycle.
    always_comb begin
        flush = (state_q == ST_FLUSH);
        stall = '0;
        if (rst && !flush) begin
            stall = stall_pattern(bus.stallreq_if, bus.stallreq_id,
                                  bus.stallreq_ex, bus.stallreq_mem);
        end
    end

    pipe_ctrl_stall_timer #(
        .W (CNT_W)
    ) u_stall_timer (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall != '0),
        .clear        (flush),
        .cnt          (dbg_stall_cnt),
        .timeout_err  (timeout_err)
    );

    assign bus.stall       = stall;
    assign bus.flush       = flush;
    assign bus.new_pc      = new_pc_q;
    assign bus.timeout_err = timeout_err;
    assign dbg_state       = state_q;

endmodule
